// File: rtl/regfile_wr_arbiter.sv
// Two-port register-file write arbiter: CPU lanes fixed, VPU/SPART fill idle ports.
// Ports: clk/rst, cpu lanes 0/1, vpu/spart req+gnt, cpu_stall, rf ports 0/1.
module regfile_wr_arbiter #(
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_we_0,
   input  logic [ADDR_W-1:0] cpu_addr_0,
   input  logic [DATA_W-1:0] cpu_data_0,
   input  logic              cpu_we_1,
   input  logic [ADDR_W-1:0] cpu_addr_1,
   input  logic [DATA_W-1:0] cpu_data_1,
   input  logic              vpu_req,
   input  logic [ADDR_W-1:0] vpu_addr,
   input  logic [DATA_W-1:0] vpu_data,
   output logic              vpu_gnt,
   input  logic              spart_req,
   input  logic [ADDR_W-1:0] spart_addr,
   input  logic [DATA_W-1:0] spart_data,
   output logic              spart_gnt,
   output logic              cpu_stall,
   output logic              rf_we_0,
   output logic [ADDR_W-1:0] rf_addr_0,
   output logic [DATA_W-1:0] rf_data_0,
   output logic              rf_we_1,
   output logic [ADDR_W-1:0] rf_addr_1,
   output logic [DATA_W-1:0] rf_data_1
);

   typedef enum logic {IDLE, STALL} state_t;

   localparam logic [3:0] LIM = STARVE_LIMIT[3:0];

   state_t            state_q, state_d;
   logic              ptr_q, ptr_d;     // 0: VPU preferred, 1: SPART preferred
   logic [3:0]        vcnt_q, vcnt_d;
   logic [3:0]        scnt_q, scnt_d;
   logic              we0_q, we0_d, we1_q, we1_d;
   logic [ADDR_W-1:0] a0_q, a0_d, a1_q, a1_d;
   logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;

   logic              stall, we0, we1, dup, free0, free1;
   logic              vcol, scol, v_ok, s_ok, same, v_el, s_el;
   logic              p_el, o_el, p_g, o_g, p_port, o_port;
   logic              vg, sg;
   logic [ADDR_W-1:0] p_addr, o_addr;
   logic [DATA_W-1:0] p_data, o_data;

   always_comb begin
      stall  = (state_q == STALL);
      // CPU writebacks are ignored while stalled
      we0    = cpu_we_0 & ~stall;
      we1    = cpu_we_1 & ~stall;
      dup    = we0 & we1 & (cpu_addr_0 == cpu_addr_1);
      free0  = ~we0;
      free1  = ~we1;
      vcol   = (we0 & (vpu_addr == cpu_addr_0)) |
               (we1 & (vpu_addr == cpu_addr_1));
      scol   = (we0 & (spart_addr == cpu_addr_0)) |
               (we1 & (spart_addr == cpu_addr_1));
      v_ok   = vpu_req & ~vcol;
      s_ok   = spart_req & ~scol;
      same   = (vpu_addr == spart_addr);
      // same-address side requests: only the preferred one stays eligible
      v_el   = v_ok & ~(same & s_ok & ptr_q);
      s_el   = s_ok & ~(same & v_ok & ~ptr_q);
      p_el   = ptr_q ? s_el : v_el;
      o_el   = ptr_q ? v_el : s_el;
      p_addr = ptr_q ? spart_addr : vpu_addr;
      p_data = ptr_q ? spart_data : vpu_data;
      o_addr = ptr_q ? vpu_addr : spart_addr;
      o_data = ptr_q ? vpu_data : spart_data;
      p_g    = p_el & (free0 | free1);
      o_g    = o_el & (p_el ? (free0 & free1) : (free0 | free1));
      p_port = ~free0;
      o_port = p_g | ~free0;
      vg     = ptr_q ? o_g : p_g;
      sg     = ptr_q ? p_g : o_g;

      we0_d = 1'b0;
      a0_d  = '0;
      d0_d  = '0;
      if (we0 && !dup) begin
         we0_d = 1'b1;
         a0_d  = cpu_addr_0;
         d0_d  = cpu_data_0;
      end else if (p_g && !p_port) begin
         we0_d = 1'b1;
         a0_d  = p_addr;
         d0_d  = p_data;
      end else if (o_g && !o_port) begin
         we0_d = 1'b1;
         a0_d  = o_addr;
         d0_d  = o_data;
      end

      we1_d = 1'b0;
      a1_d  = '0;
      d1_d  = '0;
      if (we1) begin
         we1_d = 1'b1;
         a1_d  = cpu_addr_1;
         d1_d  = cpu_data_1;
      end else if (p_g && p_port) begin
         we1_d = 1'b1;
         a1_d  = p_addr;
         d1_d  = p_data;
      end else if (o_g && o_port) begin
         we1_d = 1'b1;
         a1_d  = o_addr;
         d1_d  = o_data;
      end

      vcnt_d = '0;
      if (vpu_req && !vg)
         vcnt_d = (vcnt_q == LIM) ? LIM : vcnt_q + 4'd1;
      scnt_d = '0;
      if (spart_req && !sg)
         scnt_d = (scnt_q == LIM) ? LIM : scnt_q + 4'd1;

      ptr_d = ptr_q;
      if (vpu_req && spart_req && (vg ^ sg))
         ptr_d = ~ptr_q;

      state_d = IDLE;
      if (state_q == IDLE && (vcnt_d == LIM || scnt_d == LIM))
         state_d = STALL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         vcnt_q  <= '0;
         scnt_q  <= '0;
         we0_q   <= 1'b0;
         a0_q    <= '0;
         d0_q    <= '0;
         we1_q   <= 1'b0;
         a1_q    <= '0;
         d1_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         vcnt_q  <= vcnt_d;
         scnt_q  <= scnt_d;
         we0_q   <= we0_d;
         a0_q    <= a0_d;
         d0_q    <= d0_d;
         we1_q   <= we1_d;
         a1_q    <= a1_d;
         d1_q    <= d1_d;
      end
   end

   // grants are withheld while reset is held so nothing is accepted
   assign vpu_gnt   = vg & ~rst;
   assign spart_gnt = sg & ~rst;
   assign cpu_stall = (state_q == STALL);
   assign rf_we_0   = we0_q;
   assign rf_addr_0 = a0_q;
   assign rf_data_0 = d0_q;
   assign rf_we_1   = we1_q;
   assign rf_addr_1 = a1_q;
   assign rf_data_1 = d1_q;

endmodule
